// File: rtl/lsu_ctrl.sv
// Load/store sequencing controller: accepts one memory request at a time, checks alignment,
// drives the data-memory handshake and tags the read-data cycle for the load-register stage.
module lsu_ctrl #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TO_W           = 8
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_is_store_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   input  logic [1:0]  req_wordsize_i,
   input  logic [2:0]  req_load_instr_i,
   input  logic [5:0]  req_reg_id_i,
   output logic        mem_valid_o,
   input  logic        mem_ready_i,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic [3:0]  mem_wstrb_o,
   output logic        lr_is_load_o,
   output logic [1:0]  lr_wordsize_o,
   output logic [1:0]  lr_op1_2b_o,
   output logic [2:0]  lr_load_instr_o,
   output logic [5:0]  lr_reg_id_o,
   output logic        store_done_o,
   output logic        misalign_o,
   output logic        bus_err_o
);

   typedef enum logic {ST_IDLE = 1'b0, ST_REQ = 1'b1} state_t;

   localparam logic            TO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
   localparam logic [TO_W-1:0] CNT_ONE = TO_W'(1);

   function automatic logic f_misaligned(input logic [1:0] ws, input logic [1:0] a);
      logic bad;
      case (ws)
         2'd0:    bad = (a != 2'b00);
         2'd1:    bad = a[0];
         2'd2:    bad = 1'b0;
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   function automatic logic [3:0] f_wstrb(input logic st, input logic [1:0] ws, input logic [1:0] a);
      logic [3:0] s;
      if (!st) begin
         s = 4'b0000;
      end else begin
         case (ws)
            2'd0:    s = 4'b1111;
            2'd1:    s = a[1] ? 4'b1100 : 4'b0011;
            2'd2:    s = 4'b0001 << a;
            default: s = 4'b0000;
         endcase
      end
      return s;
   endfunction

   // Sub-word stores replicate the datum across all lanes; the strobe picks the live one.
   function automatic logic [31:0] f_wdata(input logic st, input logic [1:0] ws, input logic [31:0] d);
      logic [31:0] w;
      if (!st) begin
         w = 32'h0000_0000;
      end else begin
         case (ws)
            2'd0:    w = d;
            2'd1:    w = {2{d[15:0]}};
            2'd2:    w = {4{d[7:0]}};
            default: w = 32'h0000_0000;
         endcase
      end
      return w;
   endfunction

   state_t          r_state;
   state_t          w_next_state;
   logic            w_bad;
   logic            w_accept;
   logic            w_misalign;
   logic            w_done;
   logic            w_timeout;
   logic            r_mem_valid;
   logic [31:0]     r_mem_addr;
   logic [31:0]     r_mem_wdata;
   logic [3:0]      r_mem_wstrb;
   logic            r_is_store;
   logic [1:0]      r_wordsize;
   logic [1:0]      r_op1_2b;
   logic [2:0]      r_load_instr;
   logic [5:0]      r_reg_id;
   logic [TO_W-1:0] r_cnt;
   logic            r_store_done;
   logic            r_misalign;
   logic            r_bus_err;

   assign w_bad = f_misaligned(req_wordsize_i, req_addr_i[1:0]);

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode; a ready in the last timeout cycle still counts as a handshake.
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_misalign   = 1'b0;
      w_done       = 1'b0;
      w_timeout    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (req_valid_i && w_bad) begin
               w_misalign = 1'b1;
            end else if (req_valid_i) begin
               w_accept     = 1'b1;
               w_next_state = ST_REQ;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (mem_ready_i) begin
               w_done       = 1'b1;
               w_next_state = ST_IDLE;
            end else if (TO_EN && (r_cnt == TO_LAST)) begin
               w_timeout    = 1'b1;
               w_next_state = ST_IDLE;
            end else begin
               w_next_state = ST_REQ;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Request latches, wait counter and one-cycle status pulses.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_mem_valid  <= 1'b0;
         r_mem_addr   <= 32'h0000_0000;
         r_mem_wdata  <= 32'h0000_0000;
         r_mem_wstrb  <= 4'b0000;
         r_is_store   <= 1'b0;
         r_wordsize   <= 2'd0;
         r_op1_2b     <= 2'd0;
         r_load_instr <= 3'd0;
         r_reg_id     <= 6'd0;
         r_cnt        <= '0;
         r_store_done <= 1'b0;
         r_misalign   <= 1'b0;
         r_bus_err    <= 1'b0;
      end else begin
         r_mem_valid  <= (w_next_state == ST_REQ);
         r_store_done <= w_done & r_is_store;
         r_misalign   <= w_misalign;
         r_bus_err    <= w_timeout;
         if (w_accept) begin
            r_mem_addr   <= {req_addr_i[31:2], 2'b00};
            r_mem_wdata  <= f_wdata(req_is_store_i, req_wordsize_i, req_wdata_i);
            r_mem_wstrb  <= f_wstrb(req_is_store_i, req_wordsize_i, req_addr_i[1:0]);
            r_is_store   <= req_is_store_i;
            r_wordsize   <= req_wordsize_i;
            r_op1_2b     <= req_addr_i[1:0];
            r_load_instr <= req_load_instr_i;
            r_reg_id     <= req_reg_id_i;
            r_cnt        <= '0;
         end else if ((r_state == ST_REQ) && !mem_ready_i) begin
            r_cnt <= r_cnt + CNT_ONE;
         end else begin
            r_cnt <= r_cnt;
         end
      end
   end

   assign req_ready_o     = (r_state == ST_IDLE);
   assign lr_is_load_o    = (r_state == ST_REQ) & mem_ready_i & ~r_is_store;
   assign mem_valid_o     = r_mem_valid;
   assign mem_addr_o      = r_mem_addr;
   assign mem_wdata_o     = r_mem_wdata;
   assign mem_wstrb_o     = r_mem_wstrb;
   assign lr_wordsize_o   = r_wordsize;
   assign lr_op1_2b_o     = r_op1_2b;
   assign lr_load_instr_o = r_load_instr;
   assign lr_reg_id_o     = r_reg_id;
   assign store_done_o    = r_store_done;
   assign misalign_o      = r_misalign;
   assign bus_err_o       = r_bus_err;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: a transaction-level model is compared on every falling edge,
// and hand-computed literals pin the key cases.
module tb_lsu_ctrl;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic        req_is_store_i = 1'b0;
   logic [31:0] req_addr_i = 32'h0;
   logic [31:0] req_wdata_i = 32'h0;
   logic [1:0]  req_wordsize_i = 2'd0;
   logic [2:0]  req_load_instr_i = 3'd0;
   logic [5:0]  req_reg_id_i = 6'd0;
   logic        mem_valid_o;
   logic        mem_ready_i = 1'b0;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [3:0]  mem_wstrb_o;
   logic        lr_is_load_o;
   logic [1:0]  lr_wordsize_o;
   logic [1:0]  lr_op1_2b_o;
   logic [2:0]  lr_load_instr_o;
   logic [5:0]  lr_reg_id_o;
   logic        store_done_o;
   logic        misalign_o;
   logic        bus_err_o;

   int total = 0;
   int bad = 0;

   lsu_ctrl #(.TIMEOUT_CYCLES(TO), .TO_W(8)) dut (
      .clk(clk), .resetn(resetn),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_is_store_i(req_is_store_i), .req_addr_i(req_addr_i),
      .req_wdata_i(req_wdata_i), .req_wordsize_i(req_wordsize_i),
      .req_load_instr_i(req_load_instr_i), .req_reg_id_i(req_reg_id_i),
      .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
      .lr_is_load_o(lr_is_load_o), .lr_wordsize_o(lr_wordsize_o),
      .lr_op1_2b_o(lr_op1_2b_o), .lr_load_instr_o(lr_load_instr_o),
      .lr_reg_id_o(lr_reg_id_o), .store_done_o(store_done_o),
      .misalign_o(misalign_o), .bus_err_o(bus_err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level reference: one outstanding access, its fields and elapsed wait.
   logic        m_busy = 1'b0, m_store = 1'b0;
   logic [31:0] m_addr = 32'h0, m_wdata = 32'h0;
   logic [3:0]  m_wstrb = 4'h0;
   logic [1:0]  m_ws = 2'd0, m_lo = 2'd0;
   logic [2:0]  m_li = 3'd0;
   logic [5:0]  m_rid = 6'd0;
   int          m_wait = 0;
   logic        m_done = 1'b0, m_mis = 1'b0, m_err = 1'b0;

   function automatic logic legal(input logic [1:0] ws, input logic [31:0] a);
      int sz;
      sz = (ws == 2'd0) ? 4 : (ws == 2'd1) ? 2 : (ws == 2'd2) ? 1 : 0;
      return (sz != 0) && ((a % sz) == 0);
   endfunction

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_busy = 1'b0; m_store = 1'b0; m_addr = 32'h0; m_wdata = 32'h0; m_wstrb = 4'h0;
         m_ws = 2'd0; m_lo = 2'd0; m_li = 3'd0; m_rid = 6'd0; m_wait = 0;
         m_done = 1'b0; m_mis = 1'b0; m_err = 1'b0;
      end else begin
         m_done = 1'b0; m_mis = 1'b0; m_err = 1'b0;
         if (!m_busy) begin
            if (req_valid_i && !legal(req_wordsize_i, req_addr_i)) begin
               m_mis = 1'b1;
            end else if (req_valid_i) begin
               m_busy  = 1'b1;
               m_store = req_is_store_i;
               m_addr  = req_addr_i - (req_addr_i % 4);
               m_ws    = req_wordsize_i;
               m_lo    = req_addr_i[1:0];
               m_li    = req_load_instr_i;
               m_rid   = req_reg_id_i;
               m_wait  = 0;
               if (!req_is_store_i) begin
                  m_wstrb = 4'h0; m_wdata = 32'h0;
               end else if (req_wordsize_i == 2'd0) begin
                  m_wstrb = 4'hF; m_wdata = req_wdata_i;
               end else if (req_wordsize_i == 2'd1) begin
                  m_wstrb = (req_addr_i % 4 >= 2) ? 4'hC : 4'h3;
                  m_wdata = (req_wdata_i & 32'hFFFF) * 32'h0001_0001;
               end else begin
                  m_wstrb = 4'(1 << (req_addr_i % 4));
                  m_wdata = (req_wdata_i & 32'hFF) * 32'h0101_0101;
               end
            end
         end else if (mem_ready_i) begin
            m_busy = 1'b0;
            m_done = m_store;
         end else begin
            m_wait++;
            if (TO != 0 && m_wait == TO) begin
               m_busy = 1'b0;
               m_err  = 1'b1;
            end
         end
      end
   end

   // Compare process: every output, every falling edge.
   always @(negedge clk) begin
      chk("req_ready", 32'(req_ready_o), 32'(!m_busy));
      chk("mem_valid", 32'(mem_valid_o), 32'(m_busy));
      chk("mem_addr", mem_addr_o, m_addr);
      chk("mem_wdata", mem_wdata_o, m_wdata);
      chk("mem_wstrb", 32'(mem_wstrb_o), 32'(m_wstrb));
      chk("lr_is_load", 32'(lr_is_load_o), 32'(m_busy && mem_ready_i && !m_store));
      chk("lr_fields", {19'd0, lr_wordsize_o, lr_op1_2b_o, lr_load_instr_o, lr_reg_id_o},
          {19'd0, m_ws, m_lo, m_li, m_rid});
      chk("store_done", 32'(store_done_o), 32'(m_done));
      chk("misalign", 32'(misalign_o), 32'(m_mis));
      chk("bus_err", 32'(bus_err_o), 32'(m_err));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic st, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] ws, input logic [2:0] li, input logic [5:0] rid);
      req_is_store_i = st; req_addr_i = a; req_wdata_i = d;
      req_wordsize_i = ws; req_load_instr_i = li; req_reg_id_i = rid;
      req_valid_i = 1'b1;
      step();
      req_valid_i = 1'b0;
   endtask

   initial begin
      step(); step();
      chk("rst_mem_valid", 32'(mem_valid_o), 32'd0);
      chk("rst_ready", 32'(req_ready_o), 32'd1);
      resetn = 1'b1;
      step();

      // Load word at 0x100, ready two cycles after valid.
      issue(1'b0, 32'h100, 32'h0, 2'd0, 3'b000, 6'd5);
      chk("lw_addr", mem_addr_o, 32'h100);
      chk("lw_wstrb", 32'(mem_wstrb_o), 32'h0);
      step(); step();
      mem_ready_i = 1'b1; #1;
      chk("lw_is_load", 32'(lr_is_load_o), 32'd1);
      chk("lw_rid", 32'(lr_reg_id_o), 32'd5);
      step(); mem_ready_i = 1'b0;
      chk("lw_ready_back", 32'(req_ready_o), 32'd1);

      // Store byte 0xA5 at 0x203.
      issue(1'b1, 32'h203, 32'h1234_56A5, 2'd2, 3'b000, 6'd0);
      chk("sb_addr", mem_addr_o, 32'h200);
      chk("sb_wstrb", 32'(mem_wstrb_o), 32'h8);
      chk("sb_wdata", mem_wdata_o, 32'hA5A5_A5A5);
      mem_ready_i = 1'b1; #1;
      chk("sb_no_load", 32'(lr_is_load_o), 32'd0);
      step(); mem_ready_i = 1'b0;
      chk("sb_done", 32'(store_done_o), 32'd1);
      step();
      chk("sb_done_once", 32'(store_done_o), 32'd0);

      // Store half 0x1234 at 0x302, then misaligned requests.
      issue(1'b1, 32'h302, 32'hFFFF_1234, 2'd1, 3'b000, 6'd0);
      chk("sh_wstrb", 32'(mem_wstrb_o), 32'hC);
      chk("sh_wdata", mem_wdata_o, 32'h1234_1234);
      mem_ready_i = 1'b1; step(); mem_ready_i = 1'b0;
      issue(1'b0, 32'h301, 32'h0, 2'd1, 3'b010, 6'd9);
      chk("lh_mis", 32'(misalign_o), 32'd1);
      chk("lh_mis_noacc", 32'(mem_valid_o), 32'd0);
      step();
      chk("lh_mis_once", 32'(misalign_o), 32'd0);
      issue(1'b0, 32'h102, 32'h0, 2'd0, 3'b000, 6'd9);
      issue(1'b0, 32'h100, 32'h0, 2'd3, 3'b000, 6'd9);
      step();

      // Timeout: four cycles of valid, then bus_err.
      issue(1'b0, 32'h40, 32'h0, 2'd0, 3'b000, 6'd3);
      for (int i = 0; i < 3; i++) step();
      chk("to_valid4", 32'(mem_valid_o), 32'd1);
      step();
      chk("to_err", 32'(bus_err_o), 32'd1);
      chk("to_idle", 32'(mem_valid_o), 32'd0);
      step();

      // Ready in the fourth cycle wins over the timeout.
      issue(1'b0, 32'h44, 32'h0, 2'd0, 3'b000, 6'd4);
      for (int i = 0; i < 3; i++) step();
      mem_ready_i = 1'b1; #1;
      chk("to4_load", 32'(lr_is_load_o), 32'd1);
      step(); mem_ready_i = 1'b0;
      chk("to4_no_err", 32'(bus_err_o), 32'd0);
      step();

      // Back-to-back loads: one access every two cycles, own reg_id each.
      mem_ready_i = 1'b1; req_valid_i = 1'b1; req_is_store_i = 1'b0; req_wordsize_i = 2'd2;
      for (int k = 0; k < 4; k++) begin
         req_addr_i = 32'h80 + 32'(k) * 32'd5; req_reg_id_i = 6'(10 + k); req_load_instr_i = 3'b001;
         step();
         chk("b2b_load", 32'(lr_is_load_o), 32'd1);
         chk("b2b_rid", 32'(lr_reg_id_o), 32'(10 + k));
         req_reg_id_i = 6'd63;
         step();
      end
      req_valid_i = 1'b0; mem_ready_i = 1'b0;
      step();

      // Reset while an access is pending.
      issue(1'b1, 32'h600, 32'hDEAD_BEEF, 2'd0, 3'b000, 6'd0);
      #2 resetn = 1'b0; #1;
      chk("rst_req_valid", 32'(mem_valid_o), 32'd0);
      chk("rst_req_addr", mem_addr_o, 32'h0);
      chk("rst_req_ready", 32'(req_ready_o), 32'd1);
      step();
      resetn = 1'b1;
      step();
      issue(1'b0, 32'h500, 32'h0, 2'd0, 3'b100, 6'd7);
      chk("post_rst_addr", mem_addr_o, 32'h500);
      mem_ready_i = 1'b1; #1;
      chk("post_rst_load", 32'(lr_is_load_o), 32'd1);
      step(); mem_ready_i = 1'b0;
      step(); step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
